// File: rtl/rename_seg_ctl.sv
// Segment-header controller for the register-translation matrix.
// Keeps one rename-map checkpoint (header) per issue-queue segment.
// Retires the oldest segment in circular order once it has drained.
// Rotates ready bits so the oldest segment feeds the low pick lines.
// On a branch flush, it reloads every header with the recovered map.
module rename_seg_ctl #(
  parameter int ISQ_DEPTH = 64,
  parameter int SEG_NUM   = 2,
  parameter int LREG_NUM  = 16,
  parameter int PREG_BITS = 6,
  parameter int INST_PORT = 4,
  parameter int CNT_BITS  = 4,
  parameter int SEG_BITS  = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [CNT_BITS-1:0]                         counter,
  input  logic [ISQ_DEPTH-1:0]                        inst_done,
  input  logic [SEG_NUM*LREG_NUM*(PREG_BITS+1)-1:0]   bnd_map_flat,
  input  logic                                        flush,
  input  logic [LREG_NUM*(PREG_BITS+1)-1:0]           flush_map,
  input  logic [ISQ_DEPTH-1:0]                        inst_rdy_raw,
  output logic [ISQ_DEPTH-1:0]                        inst_rdy_reo,
  output logic [SEG_NUM*LREG_NUM*(PREG_BITS+1)-1:0]   seg_src_map_flat,
  output logic [SEG_NUM*LREG_NUM*(PREG_BITS+1)-1:0]   hed_map_flat,
  output logic [SEG_BITS-1:0]                         old_seg,
  output logic                                        seg_swt,
  output logic                                        isq_ful,
  output logic [15:0]                                 swt_cnt
);

  localparam int SEG_DEPTH = ISQ_DEPTH / SEG_NUM;
  localparam int SEG_CNT   = SEG_DEPTH / INST_PORT;
  localparam int ENT_W     = PREG_BITS + 1;
  localparam int MAP_W     = LREG_NUM * ENT_W;

  // Identity map: logical register l maps to physical register l, valid.
  function automatic logic [MAP_W-1:0] ident_map();
    logic [MAP_W-1:0] m;
    m = '0;
    for (int l = 0; l < LREG_NUM; l++) begin
      m[l*ENT_W +: ENT_W] = {1'b1, PREG_BITS'(l)};
    end
    return m;
  endfunction

  logic [MAP_W-1:0]     bnd_map [SEG_NUM];
  logic [MAP_W-1:0]     hed     [SEG_NUM];
  logic [ISQ_DEPTH-1:0] rdy_rot [SEG_NUM];
  logic [SEG_NUM-1:0]   seg_done;
  logic [LREG_NUM-1:0]  vld_vec;
  logic [MAP_W-1:0]     bnd_old;
  logic [SEG_BITS-1:0]  nxt_seg;
  logic [SEG_BITS-1:0]  prv_seg;

  assign bnd_old = bnd_map[old_seg];
  // SEG_NUM is a power of two, so the segment index wraps on its own.
  assign nxt_seg = old_seg + SEG_BITS'(1);
  assign prv_seg = old_seg - SEG_BITS'(1);

  for (genvar s = 0; s < SEG_NUM; s++) begin : g_seg
    assign bnd_map[s]  = bnd_map_flat[s*MAP_W +: MAP_W];
    assign hed_map_flat[s*MAP_W +: MAP_W] = hed[s];
    // The oldest segment starts from its own checkpoint; every other segment
    // continues from the boundary map of the segment just before it.
    assign seg_src_map_flat[s*MAP_W +: MAP_W] =
      (SEG_BITS'(s) == old_seg) ? hed[s] : bnd_map[(s + SEG_NUM - 1) % SEG_NUM];
    assign seg_done[s] = &inst_done[s*SEG_DEPTH +: SEG_DEPTH];
    // Rotation that brings line s*SEG_DEPTH down to line 0.
    assign rdy_rot[s]  = (inst_rdy_raw >> (s*SEG_DEPTH)) |
                         (inst_rdy_raw << (ISQ_DEPTH - s*SEG_DEPTH));
  end

  for (genvar l = 0; l < LREG_NUM; l++) begin : g_vld
    assign vld_vec[l] = bnd_old[l*ENT_W + PREG_BITS];
  end

  assign inst_rdy_reo = rdy_rot[old_seg];

  // Retire qualifier and full detection, both derived from the oldest segment.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // before any condition, otherwise synthesis infers a latch.
    seg_swt = 1'b0;
    isq_ful = 1'b0;
    // Allocation must have left the oldest segment, all of its lines must be
    // drained and its boundary map must be fully resolved.
    if (!flush && ((int'(counter) / SEG_CNT) != int'(old_seg)) &&
        seg_done[old_seg] && (&vld_vec)) begin
      seg_swt = 1'b1;
    end
    // Full when allocation sits on the last group of the segment directly
    // behind the oldest one.
    if (int'(counter) == int'(prv_seg) * SEG_CNT + SEG_CNT - 1) begin
      isq_ful = 1'b1;
    end
  end

  // Header, oldest-segment and retire-count registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (rst) begin
      old_seg <= '0;
      swt_cnt <= '0;
      // NOTE: the header array is reset on purpose: the first segment needs a
      // valid identity map right after reset, so it cannot be left as plain RAM.
      for (int s = 0; s < SEG_NUM; s++) begin
        hed[s] <= ident_map();
      end
    end else if (flush) begin
      for (int s = 0; s < SEG_NUM; s++) begin
        hed[s] <= flush_map;
      end
    end else if (seg_swt) begin
      hed[nxt_seg] <= bnd_old;
      old_seg      <= nxt_seg;
      if (swt_cnt != 16'hFFFF) begin
        swt_cnt <= swt_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rename_seg_ctl.sv
// Self-checking bench for rename_seg_ctl.
// Two instances share one stimulus: SEG_NUM=2 (dut0) and SEG_NUM=4 (dut1).
// A behavioural model of segments, maps and counters predicts every output.
module tb_rename_seg_ctl;

  localparam int ISQ = 64;
  localparam int LR  = 16;
  localparam int PB  = 6;
  localparam int EW  = PB + 1;
  localparam int MW  = LR * EW;
  localparam int IP  = 4;
  localparam int CB  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [CB-1:0]     counter;
  logic [ISQ-1:0]    inst_done;
  logic [ISQ-1:0]    inst_rdy_raw;
  logic              flush;
  logic [MW-1:0]     flush_map;
  logic [MW-1:0]     bnd_m [4];
  logic [2*MW-1:0]   bnd_a;
  logic [4*MW-1:0]   bnd_b;

  logic [ISQ-1:0]    reo_a, reo_b;
  logic [2*MW-1:0]   src_a, hed_a;
  logic [4*MW-1:0]   src_b, hed_b;
  logic [0:0]        old_a;
  logic [1:0]        old_b;
  logic              swt_a, swt_b, ful_a, ful_b;
  logic [15:0]       cnt_a, cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign bnd_a = {bnd_m[1], bnd_m[0]};
  assign bnd_b = {bnd_m[3], bnd_m[2], bnd_m[1], bnd_m[0]};

  rename_seg_ctl #(.ISQ_DEPTH(ISQ), .SEG_NUM(2), .LREG_NUM(LR), .PREG_BITS(PB),
                   .INST_PORT(IP), .CNT_BITS(CB), .SEG_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .counter(counter), .inst_done(inst_done),
    .bnd_map_flat(bnd_a), .flush(flush), .flush_map(flush_map),
    .inst_rdy_raw(inst_rdy_raw), .inst_rdy_reo(reo_a), .seg_src_map_flat(src_a),
    .hed_map_flat(hed_a), .old_seg(old_a), .seg_swt(swt_a), .isq_ful(ful_a),
    .swt_cnt(cnt_a));

  rename_seg_ctl #(.ISQ_DEPTH(ISQ), .SEG_NUM(4), .LREG_NUM(LR), .PREG_BITS(PB),
                   .INST_PORT(IP), .CNT_BITS(CB), .SEG_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .counter(counter), .inst_done(inst_done),
    .bnd_map_flat(bnd_b), .flush(flush), .flush_map(flush_map),
    .inst_rdy_raw(inst_rdy_raw), .inst_rdy_reo(reo_b), .seg_src_map_flat(src_b),
    .hed_map_flat(hed_b), .old_seg(old_b), .seg_swt(swt_b), .isq_ful(ful_b),
    .swt_cnt(cnt_b));

  // Observed outputs gathered into index-by-instance arrays.
  logic [ISQ-1:0] obs_reo [2];
  logic [MW-1:0]  obs_hed [2][4];
  logic [MW-1:0]  obs_src [2][4];
  int             obs_old [2];
  logic           obs_swt [2];
  logic           obs_ful [2];
  logic [15:0]    obs_cnt [2];

  always_comb begin
    for (int s = 0; s < 4; s++) begin
      obs_hed[0][s] = '0;
      obs_src[0][s] = '0;
    end
    for (int s = 0; s < 2; s++) begin
      obs_hed[0][s] = hed_a[s*MW +: MW];
      obs_src[0][s] = src_a[s*MW +: MW];
    end
    for (int s = 0; s < 4; s++) begin
      obs_hed[1][s] = hed_b[s*MW +: MW];
      obs_src[1][s] = src_b[s*MW +: MW];
    end
    obs_reo[0] = reo_a;  obs_reo[1] = reo_b;
    obs_old[0] = int'(old_a); obs_old[1] = int'(old_b);
    obs_swt[0] = swt_a;  obs_swt[1] = swt_b;
    obs_ful[0] = ful_a;  obs_ful[1] = ful_b;
    obs_cnt[0] = cnt_a;  obs_cnt[1] = cnt_b;
  end

  // ---------------- behavioural model ----------------
  int            m_old [2];
  int            m_cnt [2];
  logic [MW-1:0] m_hed [2][4];

  function automatic int sn_of(int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic logic [MW-1:0] ident();
    logic [MW-1:0] m;
    for (int l = 0; l < LR; l++) m[l*EW +: EW] = {1'b1, PB'(l)};
    return m;
  endfunction

  function automatic logic [MW-1:0] rand_map(bit all_vld);
    logic [MW-1:0] m;
    int hole;
    hole = all_vld ? -1 : int'($urandom_range(0, LR-1));
    for (int l = 0; l < LR; l++) m[l*EW +: EW] = {(l != hole), PB'($urandom)};
    return m;
  endfunction

  // Oldest segment retires when allocation is elsewhere, its lines are all
  // done and its boundary map is fully valid, unless a flush is pending.
  function automatic bit exp_swt(int k);
    int sd = ISQ / sn_of(k);
    int sc = sd / IP;
    bit ok = (flush == 1'b0) && ((int'(counter) / sc) != m_old[k]);
    for (int i = 0; i < sd; i++) if (inst_done[m_old[k]*sd + i] !== 1'b1) ok = 0;
    for (int l = 0; l < LR; l++) if (bnd_m[m_old[k]][l*EW + PB] !== 1'b1) ok = 0;
    return ok;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_old[k] = 0;
      m_cnt[k] = 0;
      for (int s = 0; s < 4; s++) m_hed[k][s] = ident();
    end
  endtask

  // Compare every output of both instances against the model, take one clock
  // edge, then advance the model with the same inputs.
  task automatic step(input string tag);
    bit             e_swt [2];
    logic [ISQ-1:0] e_reo;
    logic [MW-1:0]  e_src;
    bit             e_ful;
    int             sn, sd, sc;
    #1;
    for (int k = 0; k < 2; k++) begin
      sn = sn_of(k); sd = ISQ / sn; sc = sd / IP;
      e_swt[k] = exp_swt(k);
      n_checks++;
      if (obs_swt[k] !== e_swt[k]) begin
        n_errors++;
        $display("FAIL %s dut%0d seg_swt: got %b expected %b", tag, k, obs_swt[k], e_swt[k]);
      end
      n_checks++;
      if (obs_old[k] != m_old[k]) begin
        n_errors++;
        $display("FAIL %s dut%0d old_seg: got %0d expected %0d", tag, k, obs_old[k], m_old[k]);
      end
      n_checks++;
      if (obs_cnt[k] !== 16'(m_cnt[k])) begin
        n_errors++;
        $display("FAIL %s dut%0d swt_cnt: got %0d expected %0d", tag, k, obs_cnt[k], m_cnt[k]);
      end
      e_ful = (int'(counter) == ((m_old[k] + sn - 1) % sn) * sc + sc - 1);
      n_checks++;
      if (obs_ful[k] !== e_ful) begin
        n_errors++;
        $display("FAIL %s dut%0d isq_ful: got %b expected %b", tag, k, obs_ful[k], e_ful);
      end
      for (int i = 0; i < ISQ; i++) e_reo[i] = inst_rdy_raw[(i + m_old[k]*sd) % ISQ];
      n_checks++;
      if (obs_reo[k] !== e_reo) begin
        n_errors++;
        $display("FAIL %s dut%0d inst_rdy_reo: got %h expected %h", tag, k, obs_reo[k], e_reo);
      end
      for (int s = 0; s < sn; s++) begin
        n_checks++;
        if (obs_hed[k][s] !== m_hed[k][s]) begin
          n_errors++;
          $display("FAIL %s dut%0d hed[%0d]: got %h expected %h", tag, k, s, obs_hed[k][s], m_hed[k][s]);
        end
        e_src = (s == m_old[k]) ? m_hed[k][s] : bnd_m[(s + sn - 1) % sn];
        n_checks++;
        if (obs_src[k][s] !== e_src) begin
          n_errors++;
          $display("FAIL %s dut%0d seg_src[%0d]: got %h expected %h", tag, k, s, obs_src[k][s], e_src);
        end
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      sn = sn_of(k);
      if (flush) begin
        for (int s = 0; s < sn; s++) m_hed[k][s] = flush_map;
      end else if (e_swt[k]) begin
        m_hed[k][(m_old[k] + 1) % sn] = bnd_m[m_old[k]];
        m_old[k] = (m_old[k] + 1) % sn;
        if (m_cnt[k] < 65535) m_cnt[k]++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic retire_setup();
    flush     = 1'b0;
    counter   = 4'd8;
    inst_done = '1;
    for (int s = 0; s < 4; s++) bnd_m[s] = ident();
    bnd_m[0][3*EW +: EW] = 7'h68;  // {1, 40}
    inst_rdy_raw = {$urandom, $urandom};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    inst_rdy_raw = {$urandom, $urandom};
    do_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_old[k] != 0) begin
        n_errors++; $display("FAIL reset dut%0d old_seg: got %0d expected 0", k, obs_old[k]);
      end
      n_checks++;
      if (obs_cnt[k] !== 16'd0) begin
        n_errors++; $display("FAIL reset dut%0d swt_cnt: got %0d expected 0", k, obs_cnt[k]);
      end
      n_checks++;
      if (obs_reo[k] !== inst_rdy_raw) begin
        n_errors++; $display("FAIL reset dut%0d inst_rdy_reo: got %h expected %h", k, obs_reo[k], inst_rdy_raw);
      end
      for (int s = 0; s < sn_of(k); s++) begin
        n_checks++;
        if (obs_hed[k][s] !== ident()) begin
          n_errors++; $display("FAIL reset dut%0d hed[%0d]: got %h expected %h", k, s, obs_hed[k][s], ident());
        end
      end
    end
  endtask

  task automatic test_retire();
    do_reset();
    retire_setup();
    #1;
    n_checks++;
    if (obs_swt[0] !== 1'b1) begin
      n_errors++; $display("FAIL retire seg_swt: got %b expected 1", obs_swt[0]);
    end
    step("retire");
    n_checks++;
    if (obs_old[0] != 1) begin
      n_errors++; $display("FAIL retire old_seg: got %0d expected 1", obs_old[0]);
    end
    n_checks++;
    if (obs_hed[0][1][3*EW +: EW] !== 7'h68) begin
      n_errors++; $display("FAIL retire hed[1].e3: got %h expected 68", obs_hed[0][1][3*EW +: EW]);
    end
    n_checks++;
    if (obs_reo[0][0] !== inst_rdy_raw[32]) begin
      n_errors++; $display("FAIL retire reo[0]: got %b expected %b", obs_reo[0][0], inst_rdy_raw[32]);
    end
    n_checks++;
    if (obs_cnt[0] !== 16'd1) begin
      n_errors++; $display("FAIL retire swt_cnt: got %0d expected 1", obs_cnt[0]);
    end
  endtask

  task automatic test_blocking();
    for (int c = 0; c < 3; c++) begin
      do_reset();
      retire_setup();
      case (c)
        0:       counter = 4'd5;
        1:       inst_done[17] = 1'b0;
        default: bnd_m[0][9*EW + PB] = 1'b0;
      endcase
      #1;
      n_checks++;
      if (obs_swt[0] !== 1'b0) begin
        n_errors++; $display("FAIL block%0d seg_swt: got %b expected 0", c, obs_swt[0]);
      end
      step("block");
      n_checks++;
      if (obs_old[0] != 0) begin
        n_errors++; $display("FAIL block%0d old_seg: got %0d expected 0", c, obs_old[0]);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    retire_setup();
    flush     = 1'b1;
    flush_map = ident();
    flush_map[0 +: EW] = 7'h72;  // {1, 50}
    #1;
    n_checks++;
    if (obs_swt[0] !== 1'b0) begin
      n_errors++; $display("FAIL flush seg_swt: got %b expected 0", obs_swt[0]);
    end
    step("flush");
    flush = 1'b0;
    n_checks++;
    if (obs_old[0] != 0 || obs_cnt[0] !== 16'd0) begin
      n_errors++; $display("FAIL flush state: got old %0d cnt %0d expected old 0 cnt 0", obs_old[0], obs_cnt[0]);
    end
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (obs_hed[0][s][0 +: EW] !== 7'h72) begin
        n_errors++; $display("FAIL flush hed[%0d].e0: got %h expected 72", s, obs_hed[0][s][0 +: EW]);
      end
    end
  endtask

  task automatic test_seg4_wrap();
    int fc;
    do_reset();
    flush     = 1'b0;
    inst_done = '1;
    for (int s = 0; s < 4; s++) bnd_m[s] = rand_map(1);
    for (int o = 0; o < 5; o++) begin
      fc = ((o + 3) % 4) * 4 + 3;
      counter = CB'((fc + 1) % 16);
      #1;
      n_checks++;
      if (obs_ful[1] !== 1'b0) begin
        n_errors++; $display("FAIL wrap%0d isq_ful early: got %b expected 0", o, obs_ful[1]);
      end
      counter = CB'(fc);
      #1;
      n_checks++;
      if (obs_ful[1] !== 1'b1 || obs_old[1] != o % 4) begin
        n_errors++; $display("FAIL wrap%0d isq_ful/old: got %b/%0d expected 1/%0d", o, obs_ful[1], obs_old[1], o % 4);
      end
      if (o == 3) begin
        n_checks++;
        if (obs_src[1][0] !== bnd_m[3]) begin
          n_errors++; $display("FAIL wrap seg_src[0]: got %h expected %h", obs_src[1][0], bnd_m[3]);
        end
      end
      step("wrap");
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    retire_setup();
    step("pre_arst");
    step("pre_arst");
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs_old[0] != 0 || obs_old[1] != 0 || obs_cnt[0] !== 16'd0 || obs_hed[0][1] !== ident()) begin
      n_errors++;
      $display("FAIL arst: got old %0d/%0d cnt %0d hed1 %h expected 0/0 0 identity",
               obs_old[0], obs_old[1], obs_cnt[0], obs_hed[0][1]);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    inst_done = '0;
    step("post_arst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      counter      = CB'($urandom);
      inst_done    = '1;
      if ($urandom_range(0, 3) == 0) inst_done[$urandom_range(0, ISQ-1)] = 1'b0;
      for (int s = 0; s < 4; s++) bnd_m[s] = rand_map($urandom_range(0, 4) != 0);
      flush        = ($urandom_range(0, 9) == 0);
      flush_map    = rand_map(1);
      inst_rdy_raw = {$urandom, $urandom};
      step("random");
    end
    flush = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    flush     = 1'b0;
    inst_done = '1;
    for (int s = 0; s < 4; s++) bnd_m[s] = ident();
    for (int n = 0; n < 65537; n++) begin
      counter = (m_old[0] == 0) ? 4'd8 : 4'd0;
      step("sat");
    end
    #1;
    n_checks++;
    if (obs_cnt[0] !== 16'hFFFF) begin
      n_errors++; $display("FAIL saturate swt_cnt: got %h expected ffff", obs_cnt[0]);
    end
  endtask

  initial begin
    rst          = 1'b1;
    counter      = '0;
    inst_done    = '0;
    inst_rdy_raw = '0;
    flush        = 1'b0;
    flush_map    = '0;
    for (int s = 0; s < 4; s++) bnd_m[s] = '0;
    test_reset();
    test_retire();
    test_blocking();
    test_flush();
    test_seg4_wrap();
    test_async_reset();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rename_seg_ctl.md
Name: rename_seg_ctl

Overview:
Parametrised segment-header controller for the register-translation matrix. It generalises the two-segment top/middle header scheme to SEG_NUM segments.
- Holds one rename-map checkpoint (header) per segment and tracks which segment is architectural (oldest).
- Retires segments in circular order and injects the correct map at each segment's first line.
- Rotates ready bits so the oldest segment maps to the low lines feeding the pick logic.
- Adds behaviour the two-segment version lacks: branch-flush map recovery and a saturating switch counter.

Parameters:
ISQ_DEPTH, 64, issue-queue lines.
SEG_NUM, 2, segment count; power of two, at least 2, divides ISQ_DEPTH.
LREG_NUM, 16, logical registers.
PREG_BITS, 6, physical register index width; each map entry is {vld, preg}, PREG_BITS+1 bits.
INST_PORT, 4, lines allocated per counter step.
CNT_BITS, 4, log2(ISQ_DEPTH/INST_PORT).
SEG_BITS, 1, log2(SEG_NUM).
Derived: SEG_DEPTH=ISQ_DEPTH/SEG_NUM, SEG_CNT=SEG_DEPTH/INST_PORT, MAP_W=LREG_NUM*(PREG_BITS+1). Entry l occupies bits [(l+1)*(PREG_BITS+1)-1 : l*(PREG_BITS+1)], and its vld is the MSB.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
counter  in  CNT_BITS  allocation group pointer.
inst_done  in  ISQ_DEPTH  per line: invalid, or valid with wait and branch-wait both clear.
bnd_map_flat  in  SEG_NUM*MAP_W  slice s = cur_map of line (s+1)*SEG_DEPTH-1.
flush  in  1  misprediction recovery strobe.
flush_map  in  MAP_W  recovered architectural map; all vld bits are 1.
inst_rdy_raw  in  ISQ_DEPTH  per-line ready, physical order.
inst_rdy_reo  out  ISQ_DEPTH  ready bits rotated to priority order.
seg_src_map_flat  out  SEG_NUM*MAP_W  prv_map for line s*SEG_DEPTH.
hed_map_flat  out  SEG_NUM*MAP_W  registered headers.
old_seg  out  SEG_BITS  architectural segment index.
seg_swt  out  1  segment retire qualifier for this cycle.
isq_ful  out  1  queue full.
swt_cnt  out  16  saturating count of retirements.

Behaviour:
Reset (asynchronous, takes effect immediately and applies mid-operation too):
- old_seg=0, swt_cnt=0.
- Every header = identity map: entry l = {1, l}.
- Combinational outputs follow from these values.

seg_swt (combinational):
- Asserts when all of the following hold:
  - flush=0;
  - counter/SEG_CNT != old_seg;
  - &inst_done[old_seg*SEG_DEPTH +: SEG_DEPTH];
  - all LREG_NUM vld bits of bnd_map[old_seg] are 1.

On a clock edge with seg_swt=1:
- hed[(old_seg+1) mod SEG_NUM] <= bnd_map[old_seg].
- old_seg <= (old_seg+1) mod SEG_NUM; wraps from SEG_NUM-1 to 0.
- swt_cnt increments, saturating at 16'hFFFF.
- All other headers hold.

On a clock edge with flush=1:
- All headers <= flush_map.
- old_seg and swt_cnt hold.
- flush has priority over a switch in the same cycle, because seg_swt is forced to 0.

seg_src_map[s] (combinational):
- s==old_seg: hed[s].
- Otherwise: bnd_map[(s-1) mod SEG_NUM].

inst_rdy_reo[i] = inst_rdy_raw[(i + old_seg*SEG_DEPTH) mod ISQ_DEPTH] (combinational).

isq_ful (combinational):
- Full when counter == ((old_seg+SEG_NUM-1) mod SEG_NUM)*SEG_CNT + SEG_CNT-1.
- This is the last group of the segment just behind the oldest.

Latency and hold behaviour:
- Header and old_seg changes are visible 1 cycle after the qualifying edge.
- There is no back-pressure. At most one switch happens per cycle.
- With no switch and no flush, all registers hold.

Test Plan:
- Reset: assert rst for 2 cycles, then deassert -> old_seg=0, swt_cnt=0, hed[0]=hed[1]=identity, inst_rdy_reo==inst_rdy_raw.
- SEG_NUM=2 retire: counter=8, inst_done=all 1, bnd_map[0] all vld with entry 3={1,40} -> seg_swt=1. Next cycle old_seg=1, hed[1] entry 3={1,40}, inst_rdy_reo[0]=inst_rdy_raw[32], swt_cnt=1.
- Blocking: repeat the retire case with each one separately: counter=5 (inside old segment); inst_done[17]=0; bnd_map[0] entry 9 vld=0 -> seg_swt=0 and old_seg holds.
- Flush and switch together: flush=1 with retire conditions true and flush_map entry 0={1,50} -> seg_swt=0, old_seg unchanged, every hed entry 0={1,50}, swt_cnt unchanged.
- SEG_NUM=4 wrap and full: drive old_seg 0->1->2->3->0 via 4 retires -> isq_ful asserts at counter=15, 3, 7, 11, 15 in turn. In the old_seg=3 state, seg_src_map[0]=bnd_map[3].
- Saturation: force 65537 retires, or preload swt_cnt in simulation to 16'hFFFE and then drive 2 retires -> swt_cnt stays at 16'hFFFF.
